// File: rtl/fifo_wr_ctrl.sv
// Write-side controller for an async FIFO: a 2-entry skid buffer decouples the
// upstream valid/ready handshake from the FIFO full flag and tracks write/stall counts.
module fifo_wr_ctrl #(
   parameter int DATASIZE = 8,
   parameter int CNTSIZE  = 16
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                en,
   input  logic                s_valid,
   input  logic [DATASIZE-1:0] s_data,
   output logic                s_ready,
   input  logic                wfull,
   output logic                winc,
   output logic [DATASIZE-1:0] wdata,
   output logic [CNTSIZE-1:0]  wr_count,
   output logic [CNTSIZE-1:0]  stall_count
);

   typedef enum logic [1:0] {
      EMPTY,
      ONE,
      TWO
   } state_t;

   state_t              state, state_nxt;
   logic [DATASIZE-1:0] head, tail;
   logic                accept, push, stall;
   logic                load_head, load_tail, move_tail;

   // Handshake outputs depend on the state register only, so s_ready never
   // combinationally follows s_valid or wfull.
   assign s_ready = (state != TWO);
   assign winc    = (state != EMPTY) && en && !wfull;
   assign wdata   = head;
   assign accept  = s_valid && s_ready;
   assign push    = winc;
   assign stall   = (state != EMPTY) && en && wfull;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of process evaluation order.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) state <= EMPTY;
      else         state <= state_nxt;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can infer a latch.
      state_nxt = state;
      load_head = 1'b0;
      load_tail = 1'b0;
      move_tail = 1'b0;
      unique case (state)
         EMPTY: begin
            if (accept) begin
               load_head = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            unique case ({accept, push})
               2'b10: begin
                  load_tail = 1'b1;
                  state_nxt = TWO;
               end
               2'b01:   state_nxt = EMPTY;
               2'b11:   load_head = 1'b1;
               default: state_nxt = ONE;
            endcase
         end
         TWO: begin
            if (push) begin
               move_tail = 1'b1;
               state_nxt = ONE;
            end
         end
         default: state_nxt = EMPTY;
      endcase
   end

   // NOTE: the two entries are reset explicitly so wdata reads 0 in reset and
   // no stale word survives a mid-operation reset.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         head <= '0;
         tail <= '0;
      end else begin
         if (load_head)      head <= s_data;
         else if (move_tail) head <= tail;
         if (load_tail)      tail <= s_data;
      end
   end

   // wr_count wraps naturally; stall_count holds at all-ones.
   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wr_count    <= '0;
         stall_count <= '0;
      end else begin
         if (push)                        wr_count    <= wr_count + CNTSIZE'(1);
         if (stall && (stall_count != '1)) stall_count <= stall_count + CNTSIZE'(1);
      end
   end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: accepted words queue up in a behavioural
// model; a negedge monitor checks handshake, write order and counters each cycle.
module tb_fifo_wr_ctrl;

   localparam int DW   = 8;
   localparam int CW   = 10;
   localparam int MAXV = (1 << CW) - 1;

   logic          wclk = 1'b0;
   logic          wrst_n;
   logic          en;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          wfull;
   logic          winc;
   logic [DW-1:0] wdata;
   logic [CW-1:0] wr_count;
   logic [CW-1:0] stall_count;

   int n_checks = 0;
   int n_errors = 0;

   // Model: words accepted but not yet written, in order; the block holds at most two.
   logic [DW-1:0] sb[$];
   int            occ_q = 0;
   int            exp_wr = 0;
   int            exp_stall = 0;
   bit            done;

   fifo_wr_ctrl #(.DATASIZE(DW), .CNTSIZE(CW)) dut (
      .wclk        (wclk),
      .wrst_n      (wrst_n),
      .en          (en),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .s_ready     (s_ready),
      .wfull       (wfull),
      .winc        (winc),
      .wdata       (wdata),
      .wr_count    (wr_count),
      .stall_count (stall_count)
   );

   always #5 wclk = ~wclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stimulus side of the scoreboard: a word offered while the model has room is accepted.
   always @(posedge wclk) begin
      if (wrst_n && s_valid && occ_q < 2) sb.push_back(s_data);
   end

   // Monitor: compare DUT outputs mid-cycle, then retire the modelled write.
   always @(negedge wclk) begin
      int occ;
      bit exp_winc;
      if (!wrst_n) begin
         check("rst_s_ready", s_ready, 1);
         check("rst_winc", winc, 0);
         check("rst_wdata", wdata, 0);
         check("rst_wr_count", wr_count, 0);
         check("rst_stall_count", stall_count, 0);
         sb.delete();
         occ_q     = 0;
         exp_wr    = 0;
         exp_stall = 0;
      end else begin
         occ      = sb.size();
         occ_q    = occ;
         exp_winc = (occ > 0) && en && !wfull;
         check("s_ready", s_ready, occ < 2);
         check("winc", winc, exp_winc);
         check("wr_count", wr_count, exp_wr);
         check("stall_count", stall_count, exp_stall);
         if (exp_winc) begin
            check("wdata_order", wdata, sb[0]);
            void'(sb.pop_front());
            exp_wr = (exp_wr + 1) & MAXV;
         end
         if (occ > 0 && en && wfull && exp_stall < MAXV) exp_stall++;
      end
   end

   task automatic tick();
      @(posedge wclk);
      #1;
   endtask

   task automatic do_reset();
      wrst_n  = 1'b0;
      s_valid = 1'b0;
      repeat (2) tick();
      wrst_n = 1'b1;
   endtask

   task automatic send(input logic [DW-1:0] d);
      bit rdy;
      int guard;
      s_valid = 1'b1;
      s_data  = d;
      guard   = 0;
      do begin
         @(negedge wclk);
         rdy = s_ready;
         tick();
         guard++;
      end while (!rdy && guard < 4000);
      check("send_accepted", rdy, 1);
      s_valid = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished at %0t", $time);
      n_errors++;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1, "timeout");
   end

   initial begin
      wrst_n  = 1'b0;
      en      = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      wfull   = 1'b0;
      repeat (3) tick();
      wrst_n = 1'b1;

      // Back-to-back stream of three words.
      en = 1'b1;
      send(8'h11);
      send(8'h22);
      send(8'h33);
      repeat (3) tick();
      check("t1_wr_count", wr_count, 3);
      check("t1_stall_count", stall_count, 0);

      // FIFO full: buffer fills to two, stalls accumulate, then drains in order.
      do_reset();
      en    = 1'b1;
      wfull = 1'b1;
      send(8'hA1);
      send(8'hA2);
      repeat (4) tick();
      check("t2_s_ready", s_ready, 0);
      check("t2_winc", winc, 0);
      check("t2_stall_count", stall_count, 5);
      check("t2_head", wdata, 8'hA1);
      wfull = 1'b0;
      repeat (3) tick();
      check("t2_wr_count", wr_count, 2);

      // Disabled writes: only two words fit, nothing written or stalled until enabled.
      do_reset();
      en = 1'b0;
      fork
         begin
            send(8'h31);
            send(8'h32);
            send(8'h33);
         end
         begin
            repeat (5) tick();
            check("t3_s_ready", s_ready, 0);
            check("t3_winc", winc, 0);
            check("t3_stall_count", stall_count, 0);
            en = 1'b1;
         end
      join
      repeat (3) tick();
      check("t3_wr_count", wr_count, 3);

      // Reset while holding two words discards them.
      do_reset();
      en = 1'b1;
      send(8'h40);
      repeat (2) tick();
      en = 1'b0;
      send(8'h41);
      send(8'h42);
      en    = 1'b1;
      wfull = 1'b1;
      repeat (3) tick();
      check("t4_full_before_reset", s_ready, 0);
      wrst_n = 1'b0;
      #1;
      check("t4_async_s_ready", s_ready, 1);
      check("t4_async_winc", winc, 0);
      check("t4_async_wdata", wdata, 0);
      check("t4_async_wr_count", wr_count, 0);
      check("t4_async_stall_count", stall_count, 0);
      wfull = 1'b0;
      repeat (2) tick();
      wrst_n = 1'b1;
      repeat (5) tick();
      check("t4_no_stale_write", wr_count, 0);

      // 1000 random words with random FIFO back-pressure.
      do_reset();
      en   = 1'b1;
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 1000; i++) begin
               if ($urandom_range(3) == 0) tick();
               send(DW'($urandom));
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               wfull = ($urandom_range(2) == 0);
               tick();
            end
            wfull = 1'b0;
         end
      join
      repeat (4) tick();
      check("t5_wr_count", wr_count, 1000);
      check("t5_all_delivered", sb.size(), 0);

      // stall_count saturation, then wr_count wrap.
      do_reset();
      en    = 1'b1;
      wfull = 1'b1;
      send(8'h55);
      repeat (MAXV + 6) tick();
      check("t6_stall_saturated", stall_count, MAXV);
      wfull = 1'b0;
      do_reset();
      en = 1'b1;
      for (int i = 0; i < MAXV + 4; i++) send(DW'(i));
      repeat (3) tick();
      check("t6_wr_count_wrap", wr_count, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fifo_wr_ctrl.md
FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

Interface
REQ-001 The module SHALL have parameter DATASIZE, default 8: width of data words written into the FIFO.
REQ-002 The module SHALL have parameter CNTSIZE, default 16: width of the status counters.
REQ-003 wclk  input  1  write-domain clock; all state updates on the rising edge.
REQ-004 wrst_n  input  1  asynchronous, active-low reset.
REQ-005 en  input  1  write enable; when 0, no FIFO writes are issued.
REQ-006 s_valid  input  1  upstream word valid.
REQ-007 s_data  input  DATASIZE  upstream word.
REQ-008 s_ready  output  1  this block can accept a word.
REQ-009 wfull  input  1  FIFO full flag from the write domain.
REQ-010 winc  output  1  FIFO write strobe.
REQ-011 wdata  output  DATASIZE  FIFO write data.
REQ-012 wr_count  output  CNTSIZE  number of words written to the FIFO.
REQ-013 stall_count  output  CNTSIZE  number of cycles a word was pending but blocked by wfull.

Function
REQ-014 The block SHALL hold a 2-entry skid buffer (head, tail) controlled by an FSM with states EMPTY, ONE and TWO.
REQ-015 accept SHALL be defined as s_valid && s_ready; push SHALL be defined as winc.
REQ-016 s_ready SHALL be 1 in EMPTY and ONE and 0 in TWO, decoded only from the state register (no combinational path from s_valid or wfull).
REQ-017 winc SHALL equal (state != EMPTY) && en && !wfull; wdata SHALL always equal the head entry.
REQ-018 Every asserted winc SHALL correspond to exactly one FIFO write, because winc is never asserted while wfull=1.
REQ-019 EMPTY: on accept, s_data SHALL load into head and the FSM SHALL go to ONE; otherwise it SHALL stay in EMPTY.
REQ-020 ONE, with accept and no push: s_data SHALL load into tail and the FSM SHALL go to TWO.
REQ-021 ONE, with push and no accept: the FSM SHALL go to EMPTY.
REQ-022 ONE, with accept and push together: s_data SHALL load into head and the FSM SHALL stay in ONE.
REQ-023 ONE, with neither accept nor push: the FSM SHALL hold its state and data.
REQ-024 TWO, on push: tail SHALL move to head and the FSM SHALL go to ONE; otherwise it SHALL hold.
REQ-025 Latency from accept to the matching winc SHALL be at least 1 cycle; there is no combinational pass-through.
REQ-026 Words SHALL be written in strict acceptance order, with no loss and no duplication.
REQ-027 With en=1 and wfull=0, sustained throughput SHALL be 1 word per cycle.
REQ-028 wr_count SHALL increment by 1 on each cycle with winc=1 and wrap modulo 2^CNTSIZE.
REQ-029 stall_count SHALL increment on each cycle with state != EMPTY && en && wfull and saturate at 2^CNTSIZE-1.
REQ-030 When en=0, the buffer SHALL still fill to TWO, winc SHALL be 0 and stall_count SHALL NOT increment.
REQ-031 wfull rising while in TWO SHALL hold both entries unchanged until wfull falls.

Reset
REQ-032 On wrst_n=0 the block SHALL asynchronously enter EMPTY with head=0, tail=0, wr_count=0 and stall_count=0.
REQ-033 While in reset, outputs SHALL be s_ready=1, winc=0 and wdata=0.
REQ-034 Reset asserted mid-operation SHALL discard buffered words; no winc SHALL be issued for them after release.
REQ-035 Reset release SHALL be synchronous to wclk; the first accept is possible on the first rising edge after release.

Verification
REQ-036 Reset, then s_valid=1 with s_data=0x11,0x22,0x33 on consecutive cycles, en=1, wfull=0 -> winc high for 3 consecutive cycles starting 1 cycle after the first accept; wdata=0x11,0x22,0x33; wr_count=3.
REQ-037 wfull=1, en=1, send 0xA1 then 0xA2 -> state TWO, s_ready=0, winc=0, stall_count increments each cycle; drop wfull -> wdata=0xA1 then 0xA2 on consecutive cycles, s_ready=1 one cycle after the first write.
REQ-038 en=0 and 3 words offered -> only 2 accepted, winc=0, stall_count=0; set en=1 -> 2 writes, then the third word is accepted and written.
REQ-039 In ONE, simultaneous accept and push with 1000 random words and wfull toggling randomly -> scoreboard shows in-order, lossless delivery and wr_count=1000.
REQ-040 Assert wrst_n=0 while in TWO -> immediate s_ready=1, winc=0, counters=0; no stale word written after release.
REQ-041 Force 2^CNTSIZE+5 stall cycles -> stall_count saturates at 0xFFFF; 2^CNTSIZE+3 writes -> wr_count=3.
